// File: rtl/load_align_unit.sv
// Load path for the multicycle MIPS core: one word-aligned bus read per load,
// then byte/halfword extraction or LWL/LWR merge with selectable endianness.
module load_align_unit #(
   parameter int ADDR_W     = 32,
   parameter int BIG_ENDIAN = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [2:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_rt,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_read,
   output logic [3:0]        mem_byteenable,
   input  logic              mem_waitrequest,
   input  logic [31:0]       mem_readdata,
   output logic              resp_valid,
   output logic [31:0]       resp_data,
   output logic              resp_err
);

   typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2} state_t;

   state_t              state_r;
   logic [2:0]          op_r;
   logic [1:0]          k_r;
   logic [31:0]         rt_r;
   logic                req_ready_r;
   logic                mem_read_r;
   logic [ADDR_W-1:0]   mem_address_r;
   logic [3:0]          mem_byteenable_r;
   logic                resp_valid_r;
   logic [31:0]         resp_data_r;
   logic                resp_err_r;

   function automatic logic is_err(input logic [2:0] op, input logic [1:0] k);
      logic e;
      case (op)
         3'b010, 3'b011: e = k[0];
         3'b100:         e = (k != 2'b00);
         3'b111:         e = 1'b1;
         default:        e = 1'b0;
      endcase
      return e;
   endfunction

   // l is the lane holding the addressed byte; lc counts the lanes above it.
   function automatic logic [31:0] merge(input logic [2:0] op, input logic [1:0] k,
                                         input logic [31:0] m, input logic [31:0] rt);
      logic [1:0]  l;
      logic [1:0]  lc;
      logic [4:0]  hsh;
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      if (BIG_ENDIAN != 0) begin
         l   = 2'd3 - k;
         hsh = 5'd16 - {k, 3'b000};
      end else begin
         l   = k;
         hsh = {k, 3'b000};
      end
      lc = 2'd3 - l;
      b  = 8'(m >> {l, 3'b000});
      h  = 16'(m >> hsh);
      case (op)
         3'b000, 3'b001: r = {{24{b[7] & ~op[0]}}, b};
         3'b010, 3'b011: r = {{16{h[15] & ~op[0]}}, h};
         3'b100:         r = m;
         3'b101:         r = (m << {lc, 3'b000}) | (rt & ~(32'hFFFF_FFFF << {lc, 3'b000}));
         3'b110:         r = (m >> {l, 3'b000}) | (rt & ~(32'hFFFF_FFFF >> {l, 3'b000}));
         default:        r = rt;
      endcase
      return r;
   endfunction

   // Control FSM; every output is a register so reset clears them asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r          <= IDLE;
         op_r             <= 3'b000;
         k_r              <= 2'b00;
         rt_r             <= 32'h0000_0000;
         req_ready_r      <= 1'b1;
         mem_read_r       <= 1'b0;
         mem_address_r    <= {ADDR_W{1'b0}};
         mem_byteenable_r <= 4'b0000;
         resp_valid_r     <= 1'b0;
         resp_data_r      <= 32'h0000_0000;
         resp_err_r       <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (req_valid) begin
                  op_r        <= req_op;
                  k_r         <= req_addr[1:0];
                  rt_r        <= req_rt;
                  req_ready_r <= 1'b0;
                  if (is_err(req_op, req_addr[1:0])) begin
                     state_r      <= RESP;
                     resp_valid_r <= 1'b1;
                     resp_err_r   <= 1'b1;
                     resp_data_r  <= req_rt;
                  end else begin
                     state_r          <= BUS;
                     mem_read_r       <= 1'b1;
                     mem_byteenable_r <= 4'b1111;
                     mem_address_r    <= {req_addr[ADDR_W-1:2], 2'b00};
                  end
               end
            end
            BUS: begin
               if (!mem_waitrequest) begin
                  state_r          <= RESP;
                  mem_read_r       <= 1'b0;
                  mem_byteenable_r <= 4'b0000;
                  resp_valid_r     <= 1'b1;
                  resp_err_r       <= 1'b0;
                  resp_data_r      <= merge(op_r, k_r, mem_readdata, rt_r);
               end
            end
            RESP: begin
               state_r      <= IDLE;
               resp_valid_r <= 1'b0;
               req_ready_r  <= 1'b1;
            end
            default: begin
               state_r          <= IDLE;
               req_ready_r      <= 1'b1;
               mem_read_r       <= 1'b0;
               mem_byteenable_r <= 4'b0000;
               resp_valid_r     <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready      = req_ready_r;
   assign mem_read       = mem_read_r;
   assign mem_address    = mem_address_r;
   assign mem_byteenable = mem_byteenable_r;
   assign resp_valid     = resp_valid_r;
   assign resp_data      = resp_data_r;
   assign resp_err       = resp_err_r;

endmodule
